// File: rtl/mux_rr_arb_param.sv
// Round-robin N:1 channel multiplexer with a single registered output stage.
// Channel 0 has first priority after reset; priority then rotates past the last granted channel.
module mux_rr_arb_param #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       input_valid,
  input  logic [CHANNELS*WIDTH-1:0] input_data,
  output logic [CHANNELS-1:0]       input_ready,
  output logic                      output_valid,
  output logic [WIDTH-1:0]          output_MUX,
  output logic [SEL_W-1:0]          output_channel,
  input  logic                      output_ready
);

  logic                 vld_p0;
  logic [WIDTH-1:0]     data_p0;
  logic [SEL_W-1:0]     chan_p0;
  logic [SEL_W-1:0]     last_ptr;

  logic                 load_en;
  logic                 any_valid;
  logic [SEL_W-1:0]     grant;
  logic [WIDTH-1:0]     grant_data;

  // A full register drained this cycle may be refilled in the same cycle.
  assign load_en = !vld_p0 || output_ready;

  // Walk candidates from farthest to nearest so the nearest valid channel after last_ptr wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      int idx;
      idx = (int'(last_ptr) + k) % CHANNELS;
      if (input_valid[idx]) begin
        grant     = SEL_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign grant_data = input_data[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    input_ready = '0;
    if (!reset && load_en && any_valid)
      input_ready[grant] = 1'b1;
  end

  // Stage p0: output register and last-grant pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      chan_p0  <= '0;
      last_ptr <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      if (any_valid) begin
        vld_p0   <= 1'b1;
        data_p0  <= grant_data;
        chan_p0  <= grant;
        last_ptr <= grant;
      end else begin
        vld_p0   <= 1'b0;
      end
    end
  end

  assign output_valid   = vld_p0;
  assign output_MUX     = data_p0;
  assign output_channel = chan_p0;

endmodule

// File: tb/tb_mux_rr_arb_param.sv
// Bench for mux_rr_arb_param (WIDTH=32, CHANNELS=4): directed scenarios plus
// randomized traffic against a transaction-level round-robin reference model.
module tb_mux_rr_arb_param;
  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS-1:0]       input_valid;
  logic [CHANNELS*WIDTH-1:0] input_data;
  logic [CHANNELS-1:0]       input_ready;
  logic                      output_valid;
  logic [WIDTH-1:0]          output_MUX;
  logic [SEL_W-1:0]          output_channel;
  logic                      output_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic             m_vld;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_ptr;

  mux_rr_arb_param #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_data(input_data),
    .input_ready(input_ready), .output_valid(output_valid), .output_MUX(output_MUX),
    .output_channel(output_channel), .output_ready(output_ready)
  );

  always #5 clk = ~clk;

  // Next channel in rotation after the last grant that currently offers data, or -1.
  function automatic int model_grant();
    for (int k = 1; k <= CHANNELS; k++) begin
      int c;
      c = (m_ptr + k) % CHANNELS;
      if (input_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [CHANNELS-1:0] model_ready();
    logic [CHANNELS-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (!reset && (!m_vld || output_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_in(input logic [CHANNELS-1:0] v, input logic ordy, input logic rst);
    input_valid  = v;
    output_ready = ordy;
    reset        = rst;
    for (int i = 0; i < CHANNELS; i++) input_data[i*WIDTH +: WIDTH] = $urandom;
    #1;
  endtask

  // Advance one clock, applying the transfer rules to the model.
  task automatic tick();
    int g;
    logic n_vld; logic [WIDTH-1:0] n_data; int n_ch; int n_ptr;
    n_vld = m_vld; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr;
    g = model_grant();
    if (reset) begin
      n_vld = 1'b0; n_data = '0; n_ch = 0; n_ptr = CHANNELS - 1;
    end else if (!m_vld || output_ready) begin
      if (g >= 0) begin
        n_vld = 1'b1; n_data = input_data[g*WIDTH +: WIDTH]; n_ch = g; n_ptr = g;
      end else begin
        n_vld = 1'b0;
      end
    end
    @(posedge clk);
    m_vld = n_vld; m_data = n_data; m_ch = n_ch; m_ptr = n_ptr;
    #1;
  endtask

  task automatic test_reset();
    set_in(4'b1111, 1'b1, 1'b1);
    total++;
    if (input_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ready: got %b want 0000", input_ready);
    end
    tick();
    tick();
    total++;
    if (output_valid !== 1'b0 || output_MUX !== 32'h0 || output_channel !== 2'd0) begin
      bad++; $display("FAIL reset_state: got vld=%b mux=%h ch=%0d want 0/0/0",
                      output_valid, output_MUX, output_channel);
    end
  endtask

  task automatic test_rotate();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [CHANNELS-1:0] want;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 5; i++) begin
      set_in(4'b1111, 1'b1, 1'b0);
      want = 4'b0001 << seq[i];
      d = input_data[seq[i]*WIDTH +: WIDTH];
      total++;
      if (input_ready !== want) begin
        bad++; $display("FAIL rotate_ready[%0d]: got %b want %b", i, input_ready, want);
      end
      tick();
      total++;
      if (output_valid !== 1'b1 || output_channel !== SEL_W'(seq[i]) || output_MUX !== d) begin
        bad++; $display("FAIL rotate_out[%0d]: got vld=%b ch=%0d mux=%h want 1/%0d/%h",
                        i, output_valid, output_channel, output_MUX, seq[i], d);
      end
    end
  endtask

  task automatic test_single();
    set_in(4'b0100, 1'b1, 1'b0);
    input_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    #1;
    total++;
    if (input_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b want 0100", input_ready);
    end
    tick();
    total++;
    if (output_valid !== 1'b1 || output_MUX !== 32'hDEADBEEF || output_channel !== 2'd2) begin
      bad++; $display("FAIL single_out: got vld=%b mux=%h ch=%0d want 1/deadbeef/2",
                      output_valid, output_MUX, output_channel);
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] held;
    set_in(4'b1010, 1'b1, 1'b0);   // last grant was 2 -> channel 3 next
    tick();
    held = output_MUX;
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1010, 1'b0, 1'b0);
      total++;
      if (input_ready !== 4'b0000) begin
        bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, input_ready);
      end
      tick();
      total++;
      if (output_valid !== 1'b1 || output_MUX !== held || output_channel !== 2'd3) begin
        bad++; $display("FAIL stall_hold[%0d]: got vld=%b mux=%h ch=%0d want 1/%h/3",
                        i, output_valid, output_MUX, output_channel, held);
      end
    end
    set_in(4'b1010, 1'b1, 1'b0);
    total++;
    if (input_ready !== 4'b0010) begin
      bad++; $display("FAIL stall_release: got %b want 0010", input_ready);
    end
    tick();
    total++;
    if (output_channel !== 2'd1) begin
      bad++; $display("FAIL stall_next_ch: got %0d want 1", output_channel);
    end
  endtask

  task automatic test_wrap();
    set_in(4'b1000, 1'b1, 1'b0);
    tick();                          // last grant now 3
    set_in(4'b1001, 1'b1, 1'b0);
    total++;
    if (input_ready !== 4'b0001) begin
      bad++; $display("FAIL wrap_first: got %b want 0001", input_ready);
    end
    tick();
    set_in(4'b1001, 1'b1, 1'b0);
    total++;
    if (output_channel !== 2'd0 || input_ready !== 4'b1000) begin
      bad++; $display("FAIL wrap_second: got ch=%0d ready=%b want 0/1000", output_channel, input_ready);
    end
    tick();
    total++;
    if (output_channel !== 2'd3) begin
      bad++; $display("FAIL wrap_ch3: got %0d want 3", output_channel);
    end
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] held;
    held = output_MUX;
    set_in(4'b0000, 1'b1, 1'b0);
    total++;
    if (input_ready !== 4'b0000) begin
      bad++; $display("FAIL drain_ready: got %b want 0000", input_ready);
    end
    tick();
    total++;
    if (output_valid !== 1'b0 || output_MUX !== held || output_channel !== 2'd3) begin
      bad++; $display("FAIL drain_out: got vld=%b mux=%h ch=%0d want 0/%h/3",
                      output_valid, output_MUX, output_channel, held);
    end
  endtask

  task automatic test_reset_mid();
    set_in(4'b0100, 1'b0, 1'b0);
    tick();                          // register full and stalled
    set_in(4'b1111, 1'b0, 1'b1);
    total++;
    if (input_ready !== 4'b0000) begin
      bad++; $display("FAIL rmid_ready: got %b want 0000", input_ready);
    end
    tick();
    total++;
    if (output_valid !== 1'b0 || output_MUX !== 32'h0 || output_channel !== 2'd0) begin
      bad++; $display("FAIL rmid_state: got vld=%b mux=%h ch=%0d want 0/0/0",
                      output_valid, output_MUX, output_channel);
    end
    set_in(4'b1110, 1'b1, 1'b0);
    total++;
    if (input_ready !== 4'b0010) begin
      bad++; $display("FAIL rmid_first_grant: got %b want 0010", input_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [CHANNELS-1:0] want;
    for (int i = 0; i < 1500; i++) begin
      set_in(CHANNELS'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      want = model_ready();
      total++;
      if (input_ready !== want) begin
        bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, input_ready, want);
      end
      tick();
      total++;
      if (output_valid !== m_vld || output_MUX !== m_data || output_channel !== SEL_W'(m_ch)) begin
        bad++; $display("FAIL rand_out[%0d]: got vld=%b mux=%h ch=%0d want %b/%h/%0d",
                        i, output_valid, output_MUX, output_channel, m_vld, m_data, m_ch);
      end
    end
  endtask

  initial begin
    m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = CHANNELS - 1;
    input_valid = '0; input_data = '0; output_ready = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_rotate();
    test_single();
    test_stall();
    test_wrap();
    test_drain();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb_param.md
MUX_RR_ARB_PARAM -- requirements
Module: mux_rr_arb_param

Interface
REQ-001 Parameter WIDTH, default 32: data width of every channel, legal range 1..64.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 1..16.
REQ-003 Localparam SEL_W = max(1, clog2(CHANNELS)): width of the channel index.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 input_valid  input  CHANNELS  bit i high: channel i offers data.
REQ-007 input_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 input_ready  output  CHANNELS  bit i high: channel i data is accepted this cycle.
REQ-009 output_valid  output  1  output register holds a valid word.
REQ-010 output_MUX  output  WIDTH  registered selected data.
REQ-011 output_channel  output  SEL_W  index of the channel that supplied output_MUX.
REQ-012 output_ready  input  1  downstream accepts output_MUX this cycle.

Function
REQ-013 The block SHALL hold one output register stage (output_valid, output_MUX, output_channel) and a last-grant pointer last_ptr (SEL_W bits).
REQ-014 load_en SHALL be !output_valid || output_ready, combinational.
REQ-015 The grant SHALL be round-robin: the first channel with input_valid high, searching from last_ptr+1 upward and wrapping modulo CHANNELS, ending at last_ptr itself.
REQ-016 input_ready SHALL be one-hot or zero: bit g high only when load_en is high and granted channel g has input_valid high; all other bits low.
REQ-017 input_ready SHALL NOT depend combinationally on output_valid alone when output_ready is high; a full register drained in the same cycle accepts a new word (throughput 1 word/cycle).
REQ-018 On a cycle with input_ready[g] high, the register SHALL load input_data channel g, output_channel = g, output_valid = 1, and last_ptr = g at the next edge; latency input to output is exactly 1 cycle.
REQ-019 On a cycle with load_en high and no input_valid bit set, output_valid SHALL become 0 at the next edge; output_MUX, output_channel and last_ptr SHALL hold.
REQ-020 While output_valid is high and output_ready is low, output_MUX, output_channel and last_ptr SHALL remain stable and input_ready SHALL be all zero.
REQ-021 last_ptr SHALL change only on an accepted input transfer, never on idle or stall cycles.
REQ-022 With CHANNELS = 1 the block SHALL act as a one-deep registered pipeline stage; output_channel is constantly 0.
REQ-023 Wrap-around: with last_ptr = CHANNELS-1 the search SHALL start at channel 0.
REQ-024 Channel data with input_valid low SHALL never reach output_MUX.

Reset
REQ-025 While reset is high at a rising edge: output_valid = 0, output_MUX = 0, output_channel = 0, last_ptr = CHANNELS-1 (channel 0 has first priority after reset).
REQ-026 input_ready SHALL be all zero during any cycle in which reset is high.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; no transfer on that cycle counts as accepted.

Verification (WIDTH=32, CHANNELS=4)
REQ-028 Reset then all input_valid=4'b1111, output_ready=1 for 5 cycles -> output_channel sequence 0,1,2,3,0, one word per cycle, input_ready one-hot each cycle.
REQ-029 Only channel 2 valid, data 0xDEADBEEF, output_ready=1 -> next cycle output_valid=1, output_MUX=0xDEADBEEF, output_channel=2; input_ready=4'b0100 on the accept cycle.
REQ-030 Register full, output_ready=0 for 3 cycles with channels 1,3 valid -> output_MUX/output_channel constant, input_ready=4'b0000; release output_ready -> next grant follows last_ptr (round-robin order preserved).
REQ-031 Last grant channel 3, then channels 0 and 3 valid -> channel 0 granted (wrap-around), then channel 3.
REQ-032 Word held, output_ready=1, all input_valid=0 -> output_valid falls to 0 next cycle, output_MUX unchanged.
REQ-033 reset asserted while output_valid=1 and output_ready=0 -> next cycle output_valid=0, output_MUX=0, output_channel=0; first post-reset grant to lowest valid channel from 0.
